// File: rtl/efr_pkg.sv
// efr_pkg: shared FSM states, NoC flit constants and packet width helper for the frame reader
package efr_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  localparam logic [3:0] FLIT_SOP = 4'b0001;
  localparam logic [3:0] FLIT_EOP = 4'b1000;
  localparam logic [3:0] FLIT_ALL = 4'b1111;
  function automatic int pkt_width(input int data_w, input int id_w);
    return data_w + 2 + id_w;
  endfunction
endpackage

// File: rtl/efr_sync_fifo.sv
// efr_sync_fifo: first-word fall-through FIFO; ports clk/rst, push/din, pop/dout, empty, count
module efr_sync_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout  = mem[rp];
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/ethernet_frame_reader.sv
// ethernet_frame_reader: reads a stored frame from DDR (Avalon single-beat reads) and streams it as 4-flit NoC beats
//   cmd_*   : frame read command (bin, len_m1, frame_id, dest), valid/ready
//   avl_*   : Avalon read master toward the DDR3 controller
//   noc_*   : NoC beat output {frame_id, sop, eop, data} with per-flit valid/sop/eop
//   frames_sent, err_unexpected_rdata : status
module ethernet_frame_reader
  import efr_pkg::*;
#(
  parameter int AVL_ADDR_WIDTH     = 29,
  parameter int AVL_DATA_WIDTH     = 512,
  parameter int FRAME_ID_WIDTH     = 32,
  parameter int BIN_ADDR_WIDTH     = 8,
  parameter int FRAME_OFFSET_WIDTH = 5,
  parameter int NOC_ADDR_WIDTH     = 4,
  parameter int WIDTH_PKT          = pkt_width(AVL_DATA_WIDTH, FRAME_ID_WIDTH),
  parameter int FIFO_DEPTH         = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [BIN_ADDR_WIDTH-1:0]     cmd_bin,
  input  logic [FRAME_OFFSET_WIDTH-1:0] cmd_len_m1,
  input  logic [FRAME_ID_WIDTH-1:0]     cmd_frame_id,
  input  logic [NOC_ADDR_WIDTH-1:0]     cmd_dest,
  input  logic                          avl_ready,
  output logic                          avl_read_req,
  output logic [AVL_ADDR_WIDTH-1:0]     avl_addr,
  output logic [2:0]                    avl_size,
  input  logic                          avl_rdata_valid,
  input  logic [AVL_DATA_WIDTH-1:0]     avl_rdata,
  output logic [WIDTH_PKT-1:0]          noc_data_out,
  output logic [NOC_ADDR_WIDTH-1:0]     noc_dest_out,
  output logic [3:0]                    noc_valid_out,
  output logic [3:0]                    noc_sop_out,
  output logic [3:0]                    noc_eop_out,
  input  logic                          noc_ready_in,
  output logic [31:0]                   frames_sent,
  output logic                          err_unexpected_rdata
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  logic [BIN_ADDR_WIDTH-1:0] bin_q;
  logic [FRAME_OFFSET_WIDTH-1:0] len_q, issue_idx, send_idx;
  logic [FRAME_ID_WIDTH-1:0] id_q;
  logic [NOC_ADDR_WIDTH-1:0] dest_q;
  logic [CW-1:0] outstanding, fifo_count;
  logic [AVL_DATA_WIDTH-1:0] fifo_dout;
  logic fifo_empty, cmd_fire, rd_acc, push, pop, first, last, done;
  efr_sync_fifo #(.WIDTH(AVL_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(avl_rdata), .pop(pop),
    .dout(fifo_dout), .empty(fifo_empty), .count(fifo_count)
  );
  assign cmd_fire = cmd_valid && cmd_ready;
  assign rd_acc   = avl_read_req && avl_ready;
  // beats arriving with nothing outstanding (e.g. stale data after a reset) are dropped
  assign push     = avl_rdata_valid && outstanding != '0;
  assign pop      = !fifo_empty && noc_ready_in;
  assign first    = send_idx == '0;
  assign last     = send_idx == len_q;
  assign done     = state == DRAIN && pop && last;
  assign avl_addr = AVL_ADDR_WIDTH'({bin_q, issue_idx});
  assign avl_size = 3'd1;
  assign noc_valid_out = fifo_empty ? 4'b0 : FLIT_ALL;
  assign noc_sop_out   = (!fifo_empty && first) ? FLIT_SOP : 4'b0;
  assign noc_eop_out   = (!fifo_empty && last) ? FLIT_EOP : 4'b0;
  assign noc_data_out  = {id_q, first, last, fifo_dout};
  assign noc_dest_out  = dest_q;
  always_comb begin
    cmd_ready    = state == IDLE && !rst;
    // outstanding reads plus buffered beats never exceed the FIFO depth
    avl_read_req = state == ISSUE && (outstanding + fifo_count) < CW'(FIFO_DEPTH);
    state_n      = (state == IDLE && cmd_fire) ? ISSUE :
                   (state == ISSUE && rd_acc && issue_idx == len_q) ? DRAIN :
                   done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      bin_q                <= '0;
      len_q                <= '0;
      id_q                 <= '0;
      dest_q               <= '0;
      issue_idx            <= '0;
      send_idx             <= '0;
      outstanding          <= '0;
      frames_sent          <= '0;
      err_unexpected_rdata <= 1'b0;
    end else begin
      state <= state_n;
      if (cmd_fire) begin
        bin_q     <= cmd_bin;
        len_q     <= cmd_len_m1;
        id_q      <= cmd_frame_id;
        dest_q    <= cmd_dest;
        issue_idx <= '0;
        send_idx  <= '0;
      end else begin
        if (rd_acc) issue_idx <= issue_idx + FRAME_OFFSET_WIDTH'(1);
        if (pop) send_idx <= send_idx + FRAME_OFFSET_WIDTH'(1);
      end
      outstanding <= outstanding + CW'(rd_acc) - CW'(push);
      if (avl_rdata_valid && outstanding == '0) err_unexpected_rdata <= 1'b1;
      if (done) frames_sent <= frames_sent + 32'd1;
    end
  end
endmodule

// File: tb/tb_ethernet_frame_reader.sv
// tb_ethernet_frame_reader: scoreboard bench with a latency-modelled DDR memory and randomized backpressure
module tb_ethernet_frame_reader;
  localparam int WP = 546;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [7:0] cmd_bin = 0;
  logic [4:0] cmd_len_m1 = 0;
  logic [31:0] cmd_frame_id = 0;
  logic [3:0] cmd_dest = 0;
  logic avl_ready = 1, avl_read_req, avl_rdata_valid = 0;
  logic [28:0] avl_addr;
  logic [2:0] avl_size;
  logic [511:0] avl_rdata = '0;
  logic [WP-1:0] noc_data_out;
  logic [3:0] noc_dest_out, noc_valid_out, noc_sop_out, noc_eop_out;
  logic noc_ready_in = 1;
  logic [31:0] frames_sent;
  logic err_unexpected_rdata;

  ethernet_frame_reader dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bin(cmd_bin),
    .cmd_len_m1(cmd_len_m1), .cmd_frame_id(cmd_frame_id), .cmd_dest(cmd_dest),
    .avl_ready(avl_ready), .avl_read_req(avl_read_req), .avl_addr(avl_addr), .avl_size(avl_size),
    .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata), .noc_data_out(noc_data_out),
    .noc_dest_out(noc_dest_out), .noc_valid_out(noc_valid_out), .noc_sop_out(noc_sop_out),
    .noc_eop_out(noc_eop_out), .noc_ready_in(noc_ready_in), .frames_sent(frames_sent),
    .err_unexpected_rdata(err_unexpected_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic [WP-1:0] pkt; logic [3:0] dest;} beat_t;
  typedef struct {logic [28:0] addr; int due;} rd_t;
  beat_t exp_q[$];
  logic [28:0] exp_addr[$];
  rd_t pend[$];
  int n_chk = 0, n_fail = 0, cyc = 0, lat = 4, acc_cnt = 0, pop_cnt = 0;
  int avl_mode = 0, noc_mode = 0, exp_frames = 0;
  bit noc_stall = 0, prev_stall = 0, prev_wait = 0;
  logic [WP-1:0] prev_pkt;
  logic [3:0] prev_dest;
  logic [28:0] prev_addr;
  logic [31:0] seed;

  function automatic logic [511:0] mem_word(input logic [28:0] a);
    logic [511:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(k) * 32'h01000193) ^ seed;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // memory model, ready generators and output monitor; all sampling is 1 time unit after the falling edge
  initial begin
    rd_t r;
    beat_t e;
    forever begin
      @(negedge clk);
      avl_ready = avl_mode == 0 ? 1'b1 : avl_mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
      noc_ready_in = noc_stall ? 1'b0 : noc_mode == 0 ? 1'b1 : $urandom_range(0, 3) != 0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        avl_rdata_valid = 1;
        avl_rdata = mem_word(r.addr);
      end else begin
        avl_rdata_valid = 0;
        avl_rdata = '0;
      end
      #1;
      if (rst) begin
        prev_stall = 0;
        prev_wait = 0;
      end else begin
        if (prev_wait) chk("avl_hold", {avl_read_req, avl_addr}, {1'b1, prev_addr});
        if (avl_read_req && avl_ready) begin
          acc_cnt++;
          chk("avl_size", avl_size, 1);
          chk("credit", (acc_cnt - pop_cnt) <= 32, 1);
          if (exp_addr.size() == 0) fail_now($sformatf("unexpected_read addr %0h", avl_addr));
          else chk("read_addr", avl_addr, exp_addr.pop_front());
          pend.push_back('{avl_addr, cyc + lat});
        end
        prev_wait = avl_read_req && !avl_ready;
        prev_addr = avl_addr;
        if (noc_valid_out != 0) begin
          if (prev_stall) chk("noc_hold", {noc_data_out, noc_dest_out}, {prev_pkt, prev_dest});
          if (noc_ready_in) begin
            pop_cnt++;
            if (exp_q.size() == 0) fail_now($sformatf("unexpected_beat data %0h", noc_data_out));
            else begin
              e = exp_q.pop_front();
              chk("noc_data", noc_data_out, e.pkt);
              chk("noc_ctrl", {noc_valid_out, noc_sop_out, noc_eop_out, noc_dest_out},
                  {4'hF, e.pkt[513] ? 4'h1 : 4'h0, e.pkt[512] ? 4'h8 : 4'h0, e.dest});
            end
          end
          prev_stall = !noc_ready_in;
          prev_pkt = noc_data_out;
          prev_dest = noc_dest_out;
        end else prev_stall = 0;
      end
      cyc++;
    end
  end

  task automatic send_cmd(input logic [7:0] b, input logic [4:0] lm1, input logic [31:0] id, input logic [3:0] d);
    int t = 0;
    logic [28:0] a;
    @(negedge clk);
    cmd_valid = 1; cmd_bin = b; cmd_len_m1 = lm1; cmd_frame_id = id; cmd_dest = d;
    #2;
    while (!cmd_ready && t < 3000) begin
      @(negedge clk); #2; t++;
    end
    if (!cmd_ready) fail_now("cmd_timeout");
    else begin
      chk("cmd_ready_after_eop", exp_q.size(), 0);
      for (int i = 0; i <= int'(lm1); i++) begin
        a = {16'b0, b, 5'(i)};
        exp_addr.push_back(a);
        exp_q.push_back('{{id, i == 0, i == int'(lm1), mem_word(a)}, d});
      end
    end
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk); #2; t++;
    end while ((exp_q.size() > 0 || exp_addr.size() > 0 || pend.size() > 0 || !cmd_ready) && t < 5000);
    if (t >= 5000) fail_now("idle_timeout");
    chk("frames_sent", frames_sent, exp_frames);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1;
    #2;
    chk("cmd_ready_in_rst", cmd_ready, 0);
    exp_q.delete();
    exp_addr.delete();
    acc_cnt = 0;
    pop_cnt = 0;
    exp_frames = 0;
    repeat (n) @(negedge clk);
    rst = 0;
    #2;
    chk("reset_state", {cmd_ready, avl_read_req, noc_valid_out, noc_sop_out, noc_eop_out, frames_sent, err_unexpected_rdata},
        {1'b1, 1'b0, 12'h0, 32'h0, 1'b0});
  endtask

  initial begin
    int base, t;
    seed = $urandom;
    do_reset(3);
    lat = 3;
    send_cmd(8'h03, 5'd0, 32'h1000_0001, 4'h5);
    exp_frames++;
    wait_idle();
    lat = 10;
    send_cmd(8'hFF, 5'd31, $urandom, 4'($urandom));
    exp_frames++;
    wait_idle();
    avl_mode = 1; lat = 5;
    send_cmd(8'($urandom), 5'd7, $urandom, 4'($urandom));
    exp_frames++;
    wait_idle();
    avl_mode = 0;
    noc_stall = 1;
    send_cmd(8'($urandom), 5'd31, $urandom, 4'($urandom));
    repeat (100) @(negedge clk);
    #2;
    chk("stall_reserved", acc_cnt - pop_cnt, 32);
    chk("stall_no_req", avl_read_req, 0);
    noc_stall = 0;
    exp_frames++;
    wait_idle();
    send_cmd(8'($urandom), 5'($urandom), $urandom, 4'($urandom));
    send_cmd(8'($urandom), 5'($urandom), $urandom, 4'($urandom));
    exp_frames += 2;
    wait_idle();
    for (int n = 0; n < 6; n++) begin
      avl_mode = $urandom_range(0, 2);
      noc_mode = $urandom_range(0, 1);
      lat = $urandom_range(1, 12);
      send_cmd(8'($urandom), 5'($urandom), $urandom, 4'($urandom));
      exp_frames++;
      wait_idle();
    end
    avl_mode = 0; noc_mode = 0; lat = 10;
    chk("err_clean", err_unexpected_rdata, 0);
    base = acc_cnt;
    send_cmd(8'($urandom), 5'd15, $urandom, 4'($urandom));
    t = 0;
    while (acc_cnt - base < 5 && t < 200) begin
      @(negedge clk); #2; t++;
    end
    if (acc_cnt - base < 5) fail_now("reset_setup_timeout");
    do_reset(2);
    t = 0;
    while (pend.size() > 0 && t < 200) begin
      @(negedge clk); #2; t++;
    end
    repeat (4) @(negedge clk);
    #2;
    chk("err_sticky", err_unexpected_rdata, 1);
    chk("frames_after_rst", frames_sent, 0);
    send_cmd(8'($urandom), 5'($urandom), $urandom, 4'($urandom));
    exp_frames++;
    wait_idle();
    chk("err_still_set", err_unexpected_rdata, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule
